knn_scan_controller: RTL and testbench

Sequencer for the 2-D distance datapath in the KNN accelerator. On `start`, it latches a query point and scans the training-point memory, one point per cycle. It feeds each stored point and the query to the combinational distance engine, and keeps a sorted list of the K nearest points (index and squared distance). It sits between the top-level classifier FSM and the point RAM / distance engine pair.

---
 rtl/knn_scan_controller.sv | 194 +++++++++++++++++++
 tb/tb_knn_scan_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_scan_controller.sv
// knn_scan_controller: scans the point RAM one point per cycle against a latched
// query and keeps a sorted list of the K nearest points (index and squared distance).
module knn_scan_controller #(
    parameter int unsigned N_POINTS = 64,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned K        = 3,
    parameter int unsigned DIST_W   = 18
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [7:0]            i_x_in,
    input  logic [7:0]            i_y_in,
    output logic                  o_mem_rd_en,
    output logic [ADDR_W-1:0]     o_mem_addr,
    input  logic [7:0]            i_mem_x,
    input  logic [7:0]            i_mem_y,
    output logic [7:0]            o_eng_x_in,
    output logic [7:0]            o_eng_y_in,
    output logic [7:0]            o_eng_x_mem,
    output logic [7:0]            o_eng_y_mem,
    input  logic [DIST_W-1:0]     i_eng_dist,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [K*ADDR_W-1:0]   o_nn_idx,
    output logic [K*DIST_W-1:0]   o_nn_dist,
    output logic [K-1:0]          o_nn_valid
);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_drain;
    logic                r_v0;
    logic [ADDR_W-1:0]   r_idx0;
    logic                r_v1;
    logic [ADDR_W-1:0]   r_idx1;
    logic [7:0]          r_qx;
    logic [7:0]          r_qy;
    logic [7:0]          r_mx;
    logic [7:0]          r_my;
    logic [ADDR_W-1:0]   r_nn_idx   [K];
    logic [DIST_W-1:0]   r_nn_dist  [K];
    logic [K-1:0]        r_nn_valid;

    logic                w_accept;
    logic                w_last_addr;
    logic [K-1:0]        w_le;
    logic [ADDR_W-1:0]   w_new_idx  [K];
    logic [DIST_W-1:0]   w_new_dist [K];
    logic [K-1:0]        w_new_valid;

    assign w_accept    = (r_state == StIdle) && i_start;
    assign w_last_addr = (r_addr == ADDR_W'(N_POINTS - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: DRAIN lasts two cycles to flush the read and operand stages
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StScan;
            StScan:  if (w_last_addr) w_state_next = StDrain;
            StDrain: if (r_drain) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        o_mem_rd_en = (r_state == StScan);
        o_busy      = (r_state == StScan) || (r_state == StDrain);
        o_done      = (r_state == StDone);
    end

    // Address counter and drain-cycle toggle; the counter holds at the last address
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_addr  <= '0;
            r_drain <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= '0;
            end else if ((r_state == StScan) && !w_last_addr) begin
                r_addr <= r_addr + 1'b1;
            end
            r_drain <= (r_state == StDrain) ? ~r_drain : 1'b0;
        end
    end

    // Query latch and read/operand pipeline (v0: read in flight, v1: operands valid)
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_qx   <= '0;
            r_qy   <= '0;
            r_mx   <= '0;
            r_my   <= '0;
            r_v0   <= 1'b0;
            r_idx0 <= '0;
            r_v1   <= 1'b0;
            r_idx1 <= '0;
        end else begin
            if (w_accept) begin
                r_qx <= i_x_in;
                r_qy <= i_y_in;
            end
            r_v0   <= (r_state == StScan);
            r_idx0 <= r_addr;
            r_v1   <= r_v0;
            if (r_v0) begin
                r_mx   <= i_mem_x;
                r_my   <= i_mem_y;
                r_idx1 <= r_idx0;
            end
        end
    end

    // Sorted insertion: w_le is a thermometer over the valid prefix, so the first
    // slot with w_le=0 takes the candidate and everything below it shifts down.
    // Using <= keeps an earlier index ahead of a later one on equal distance.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            w_le[j]        = r_nn_valid[j] && (r_nn_dist[j] <= i_eng_dist);
            w_new_idx[j]   = r_nn_idx[j];
            w_new_dist[j]  = r_nn_dist[j];
            w_new_valid[j] = r_nn_valid[j];
        end
        if (!w_le[0]) begin
            w_new_idx[0]   = r_idx1;
            w_new_dist[0]  = i_eng_dist;
            w_new_valid[0] = 1'b1;
        end
        for (int j = 1; j < K; j++) begin
            if (!w_le[j]) begin
                if (w_le[j-1]) begin
                    w_new_idx[j]   = r_idx1;
                    w_new_dist[j]  = i_eng_dist;
                    w_new_valid[j] = 1'b1;
                end else begin
                    w_new_idx[j]   = r_nn_idx[j-1];
                    w_new_dist[j]  = r_nn_dist[j-1];
                    w_new_valid[j] = r_nn_valid[j-1];
                end
            end
        end
    end

    // Top-K list: cleared on start, updated once per valid operand pair
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_nn_valid <= '0;
            for (int j = 0; j < K; j++) begin
                r_nn_idx[j]  <= '0;
                r_nn_dist[j] <= '0;
            end
        end else if (w_accept) begin
            r_nn_valid <= '0;
        end else if (r_v1) begin
            r_nn_valid <= w_new_valid;
            for (int j = 0; j < K; j++) begin
                r_nn_idx[j]  <= w_new_idx[j];
                r_nn_dist[j] <= w_new_dist[j];
            end
        end
    end

    // Flatten the neighbour list, slot 0 in the LSBs
    always_comb begin
        o_nn_idx  = '0;
        o_nn_dist = '0;
        for (int j = 0; j < K; j++) begin
            o_nn_idx[j*ADDR_W +: ADDR_W]  = r_nn_idx[j];
            o_nn_dist[j*DIST_W +: DIST_W] = r_nn_dist[j];
        end
    end

    assign o_nn_valid  = r_nn_valid;
    assign o_mem_addr  = r_addr;
    assign o_eng_x_in  = r_qx;
    assign o_eng_y_in  = r_qy;
    assign o_eng_x_mem = r_mx;
    assign o_eng_y_mem = r_my;

endmodule

// File: tb/tb_knn_scan_controller.sv
// Bench for knn_scan_controller: two instances (N_POINTS=4 and N_POINTS=2, K=3) with
// a registered point-RAM model and a combinational distance engine each.
module tb_knn_scan_controller;
    localparam int AW = 6;
    localparam int KK = 3;
    localparam int DW = 18;
    localparam int NA = 4;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    function automatic logic [DW-1:0] sqd(input logic [7:0] ax, input logic [7:0] ay,
                                          input logic [7:0] bx, input logic [7:0] by);
        int dx;
        int dy;
        dx = int'(ax) - int'(bx);
        dy = int'(ay) - int'(by);
        return DW'(dx * dx + dy * dy);
    endfunction

    // Instance A
    logic a_start;
    logic [7:0] a_x, a_y, a_mx, a_my, a_ex, a_ey, a_emx, a_emy;
    logic a_rd, a_busy, a_done;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_dist;
    logic [KK*AW-1:0] a_idx;
    logic [KK*DW-1:0] a_nd;
    logic [KK-1:0] a_val;
    logic [7:0] mem_a_x [64];
    logic [7:0] mem_a_y [64];

    knn_scan_controller #(.N_POINTS(NA), .ADDR_W(AW), .K(KK), .DIST_W(DW)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_x_in(a_x), .i_y_in(a_y),
        .o_mem_rd_en(a_rd), .o_mem_addr(a_addr), .i_mem_x(a_mx), .i_mem_y(a_my),
        .o_eng_x_in(a_ex), .o_eng_y_in(a_ey), .o_eng_x_mem(a_emx), .o_eng_y_mem(a_emy),
        .i_eng_dist(a_dist), .o_busy(a_busy), .o_done(a_done),
        .o_nn_idx(a_idx), .o_nn_dist(a_nd), .o_nn_valid(a_val)
    );

    always @(posedge clk) if (a_rd) begin
        a_mx <= mem_a_x[a_addr];
        a_my <= mem_a_y[a_addr];
    end
    assign a_dist = sqd(a_ex, a_ey, a_emx, a_emy);

    // Instance B
    logic b_start;
    logic [7:0] b_x, b_y, b_mx, b_my, b_ex, b_ey, b_emx, b_emy;
    logic b_rd, b_busy, b_done;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dist;
    logic [KK*AW-1:0] b_idx;
    logic [KK*DW-1:0] b_nd;
    logic [KK-1:0] b_val;
    logic [7:0] mem_b_x [64];
    logic [7:0] mem_b_y [64];

    knn_scan_controller #(.N_POINTS(NB), .ADDR_W(AW), .K(KK), .DIST_W(DW)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_x_in(b_x), .i_y_in(b_y),
        .o_mem_rd_en(b_rd), .o_mem_addr(b_addr), .i_mem_x(b_mx), .i_mem_y(b_my),
        .o_eng_x_in(b_ex), .o_eng_y_in(b_ey), .o_eng_x_mem(b_emx), .o_eng_y_mem(b_emy),
        .i_eng_dist(b_dist), .o_busy(b_busy), .o_done(b_done),
        .o_nn_idx(b_idx), .o_nn_dist(b_nd), .o_nn_valid(b_val)
    );

    always @(posedge clk) if (b_rd) begin
        b_mx <= mem_b_x[b_addr];
        b_my <= mem_b_y[b_addr];
    end
    assign b_dist = sqd(b_ex, b_ey, b_emx, b_emy);

    // Reference model: repeatedly pick the unused point with the smallest distance,
    // lowest index first on ties.
    logic [KK*AW-1:0] exp_idx;
    logic [KK*DW-1:0] exp_dist;
    logic [KK-1:0]    exp_val;

    task automatic model(input logic [7:0] qx, input logic [7:0] qy, input int n,
                         input bit use_b);
        bit used [64];
        int best;
        logic [DW-1:0] bd, d;
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        exp_idx = '0;
        exp_dist = '0;
        exp_val = '0;
        for (int s = 0; s < KK; s++) begin
            best = -1;
            bd = '0;
            for (int i = 0; i < n; i++) begin
                d = use_b ? sqd(qx, qy, mem_b_x[i], mem_b_y[i])
                          : sqd(qx, qy, mem_a_x[i], mem_a_y[i]);
                if (!used[i] && (best < 0 || d < bd)) begin
                    best = i;
                    bd = d;
                end
            end
            if (best >= 0) begin
                used[best] = 1'b1;
                exp_idx[s*AW +: AW] = AW'(best);
                exp_dist[s*DW +: DW] = bd;
                exp_val[s] = 1'b1;
            end
        end
    endtask

    // Scan driver for A; tracks protocol errors cycle by cycle
    int a_done_cyc, a_seq_err, a_op_err, a_busy_err;

    task automatic run_scan_a(input logic [7:0] qx, input logic [7:0] qy,
                              input int pulse_cyc, input int rst_cyc);
        int cyc;
        a_done_cyc = -1;
        a_seq_err = 0;
        a_op_err = 0;
        a_busy_err = 0;
        @(negedge clk);
        a_start = 1'b1;
        a_x = qx;
        a_y = qy;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            a_start = (cyc == pulse_cyc);
            a_x = 8'($urandom);
            a_y = 8'($urandom);
            if (cyc == rst_cyc) begin
                a_start = 1'b0;
                rst = 1'b0;
                #1;
                return;
            end
            if (a_rd !== (cyc <= NA)) a_seq_err++;
            if (cyc <= NA && a_addr !== AW'(cyc - 1)) a_seq_err++;
            if (a_busy !== (cyc <= NA + 2)) a_busy_err++;
            if (cyc >= 3 && cyc < 3 + NA &&
                (a_emx !== mem_a_x[cyc-3] || a_emy !== mem_a_y[cyc-3])) a_op_err++;
            if (a_done) begin
                a_done_cyc = cyc;
                break;
            end
        end
        a_start = 1'b0;
    endtask

    int b_done_cyc;

    task automatic run_scan_b(input logic [7:0] qx, input logic [7:0] qy);
        int cyc;
        b_done_cyc = -1;
        @(negedge clk);
        b_start = 1'b1;
        b_x = qx;
        b_y = qy;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            b_start = 1'b0;
            if (b_done) begin
                b_done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic set_a(input int i, input logic [7:0] x, input logic [7:0] y);
        mem_a_x[i] = x;
        mem_a_y[i] = y;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({a_rd, a_addr, a_busy, a_done, a_ex, a_ey, a_emx, a_emy, a_idx, a_nd, a_val} !== '0)
            $display("FAIL reset_a: got rd=%0b addr=%0d busy=%0b done=%0b idx=%0h dist=%0h val=%0b, want all 0",
                     a_rd, a_addr, a_busy, a_done, a_idx, a_nd, a_val);
        else pass_cnt++;
        chk_cnt++;
        if ({b_rd, b_addr, b_busy, b_done, b_ex, b_ey, b_emx, b_emy, b_idx, b_nd, b_val} !== '0)
            $display("FAIL reset_b: got rd=%0b addr=%0d busy=%0b done=%0b val=%0b, want all 0",
                     b_rd, b_addr, b_busy, b_done, b_val);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        set_a(0, 3, 4); set_a(1, 1, 1); set_a(2, 10, 0); set_a(3, 0, 2);
        run_scan_a(0, 0, -1, -1);
        chk_cnt++;
        if (a_done_cyc !== 7) $display("FAIL basic_done_cycle: got %0d want 7", a_done_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (a_idx !== {6'd0, 6'd3, 6'd1}) $display("FAIL basic_idx: got %0h want %0h", a_idx, {6'd0, 6'd3, 6'd1});
        else pass_cnt++;
        chk_cnt++;
        if (a_nd !== {18'd25, 18'd4, 18'd2}) $display("FAIL basic_dist: got %0h want %0h", a_nd, {18'd25, 18'd4, 18'd2});
        else pass_cnt++;
        chk_cnt++;
        if (a_val !== 3'b111) $display("FAIL basic_valid: got %b want 111", a_val);
        else pass_cnt++;
        chk_cnt++;
        if (a_seq_err + a_op_err + a_busy_err != 0)
            $display("FAIL basic_protocol: got seq=%0d op=%0d busy=%0d errors want 0", a_seq_err, a_op_err, a_busy_err);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (a_idx !== {6'd0, 6'd3, 6'd1} || a_val !== 3'b111 || a_done !== 1'b0)
            $display("FAIL basic_hold: got idx=%0h val=%b done=%b want idx=%0h val=111 done=0",
                     a_idx, a_val, a_done, {6'd0, 6'd3, 6'd1});
        else pass_cnt++;
    endtask

    task automatic test_tie();
        set_a(0, 6, 5); set_a(1, 4, 5); set_a(2, 5, 5); set_a(3, 9, 9);
        run_scan_a(5, 5, -1, -1);
        chk_cnt++;
        if (a_idx !== {6'd1, 6'd0, 6'd2}) $display("FAIL tie_idx: got %0h want %0h", a_idx, {6'd1, 6'd0, 6'd2});
        else pass_cnt++;
        chk_cnt++;
        if (a_nd !== {18'd1, 18'd1, 18'd0}) $display("FAIL tie_dist: got %0h want %0h", a_nd, {18'd1, 18'd1, 18'd0});
        else pass_cnt++;
    endtask

    task automatic test_extremes();
        for (int i = 0; i < NA; i++) set_a(i, 255, 255);
        run_scan_a(0, 0, -1, -1);
        chk_cnt++;
        if (a_nd[DW-1:0] !== 18'd130050) $display("FAIL extreme_far: got %0d want 130050", a_nd[DW-1:0]);
        else pass_cnt++;
        for (int i = 0; i < NA; i++) set_a(i, 0, 0);
        run_scan_a(255, 255, -1, -1);
        chk_cnt++;
        if (a_nd[DW-1:0] !== 18'd130050) $display("FAIL extreme_near: got %0d want 130050", a_nd[DW-1:0]);
        else pass_cnt++;
        chk_cnt++;
        if (a_idx !== {6'd2, 6'd1, 6'd0}) $display("FAIL extreme_idx: got %0h want %0h", a_idx, {6'd2, 6'd1, 6'd0});
        else pass_cnt++;
    endtask

    task automatic test_start_during_scan();
        int extra;
        set_a(0, 9, 1); set_a(1, 2, 2); set_a(2, 7, 7); set_a(3, 1, 0);
        model(8, 1, NA, 1'b0);
        run_scan_a(8, 1, 2, -1);
        chk_cnt++;
        if (a_done_cyc !== NA + 3 || a_seq_err + a_busy_err + a_op_err != 0)
            $display("FAIL start_ignored_seq: got done_cycle=%0d seq=%0d busy=%0d op=%0d want done_cycle=%0d and 0 errors",
                     a_done_cyc, a_seq_err, a_busy_err, a_op_err, NA + 3);
        else pass_cnt++;
        chk_cnt++;
        if (a_idx !== exp_idx || a_nd !== exp_dist)
            $display("FAIL start_ignored_result: got idx=%0h dist=%0h want idx=%0h dist=%0h", a_idx, a_nd, exp_idx, exp_dist);
        else pass_cnt++;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_done === 1'b1 || a_busy === 1'b1) extra++;
        end
        chk_cnt++;
        if (extra != 0) $display("FAIL start_ignored_one_done: got %0d extra active cycles want 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        set_a(0, 1, 1); set_a(1, 1, 2); set_a(2, 2, 1); set_a(3, 3, 3);
        run_scan_a(0, 0, -1, 2);
        chk_cnt++;
        if ({a_rd, a_addr, a_busy, a_done, a_ex, a_ey, a_emx, a_emy, a_idx, a_nd, a_val} !== '0)
            $display("FAIL midscan_reset: got rd=%0b addr=%0d busy=%0b ex=%0h emx=%0h idx=%0h val=%b want all 0",
                     a_rd, a_addr, a_busy, a_ex, a_emx, a_idx, a_val);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_done === 1'b1 || a_busy === 1'b1) seen++;
        end
        chk_cnt++;
        if (seen != 0) $display("FAIL midscan_abandon: got %0d active cycles want 0", seen);
        else pass_cnt++;
        set_a(0, 200, 200); set_a(1, 100, 90); set_a(2, 150, 10); set_a(3, 99, 91);
        model(100, 100, NA, 1'b0);
        run_scan_a(100, 100, -1, -1);
        chk_cnt++;
        if (a_idx !== exp_idx || a_nd !== exp_dist || a_val !== exp_val || a_done_cyc !== NA + 3)
            $display("FAIL midscan_restart: got idx=%0h dist=%0h val=%b cyc=%0d want idx=%0h dist=%0h val=%b cyc=%0d",
                     a_idx, a_nd, a_val, a_done_cyc, exp_idx, exp_dist, exp_val, NA + 3);
        else pass_cnt++;
    endtask

    task automatic test_small_n();
        mem_b_x[0] = 1; mem_b_y[0] = 2;
        mem_b_x[1] = 7; mem_b_y[1] = 7;
        model(0, 0, NB, 1'b1);
        run_scan_b(0, 0);
        chk_cnt++;
        if (b_done_cyc !== 5) $display("FAIL smalln_done_cycle: got %0d want 5", b_done_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (b_val !== 3'b011) $display("FAIL smalln_valid: got %b want 011", b_val);
        else pass_cnt++;
        chk_cnt++;
        if (b_idx[2*AW-1:0] !== exp_idx[2*AW-1:0] || b_nd[2*DW-1:0] !== exp_dist[2*DW-1:0])
            $display("FAIL smalln_result: got idx=%0h dist=%0h want idx=%0h dist=%0h",
                     b_idx[2*AW-1:0], b_nd[2*DW-1:0], exp_idx[2*AW-1:0], exp_dist[2*DW-1:0]);
        else pass_cnt++;
        model(7, 6, NB, 1'b1);
        run_scan_b(7, 6);
        chk_cnt++;
        if (b_done_cyc !== 5 || b_val !== 3'b011)
            $display("FAIL b2b_done_valid: got cyc=%0d val=%b want cyc=5 val=011", b_done_cyc, b_val);
        else pass_cnt++;
        chk_cnt++;
        if (b_idx[2*AW-1:0] !== exp_idx[2*AW-1:0] || b_nd[2*DW-1:0] !== exp_dist[2*DW-1:0])
            $display("FAIL b2b_result: got idx=%0h dist=%0h want idx=%0h dist=%0h",
                     b_idx[2*AW-1:0], b_nd[2*DW-1:0], exp_idx[2*AW-1:0], exp_dist[2*DW-1:0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] qx, qy;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < NA; i++) begin
                if (it < 15) set_a(i, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
                else set_a(i, 8'($urandom), 8'($urandom));
            end
            qx = (it < 15) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            qy = (it < 15) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            model(qx, qy, NA, 1'b0);
            run_scan_a(qx, qy, -1, -1);
            chk_cnt++;
            if (a_idx !== exp_idx) $display("FAIL rand_idx[%0d]: got %0h want %0h", it, a_idx, exp_idx);
            else pass_cnt++;
            chk_cnt++;
            if (a_nd !== exp_dist) $display("FAIL rand_dist[%0d]: got %0h want %0h", it, a_nd, exp_dist);
            else pass_cnt++;
            chk_cnt++;
            if (a_val !== exp_val || a_done_cyc !== NA + 3)
                $display("FAIL rand_valid_cycle[%0d]: got val=%b cyc=%0d want val=%b cyc=%0d",
                         it, a_val, a_done_cyc, exp_val, NA + 3);
            else pass_cnt++;
            chk_cnt++;
            if (a_seq_err + a_op_err + a_busy_err != 0)
                $display("FAIL rand_protocol[%0d]: got seq=%0d op=%0d busy=%0d want 0",
                         it, a_seq_err, a_op_err, a_busy_err);
            else pass_cnt++;
        end
    endtask

    initial begin
        a_start = 1'b0; a_x = '0; a_y = '0;
        b_start = 1'b0; b_x = '0; b_y = '0;
        for (int i = 0; i < 64; i++) begin
            mem_a_x[i] = '0; mem_a_y[i] = '0;
            mem_b_x[i] = '0; mem_b_y[i] = '0;
        end
        test_reset();
        test_basic();
        test_tie();
        test_extremes();
        test_start_during_scan();
        test_reset_mid_scan();
        test_small_n();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
